// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative RV32M multiply/divide
// sequencer.
//   - OP_* : RV32M funct3 encodings.
//   - state_t : sequencer states, listed in the order the FSM walks them.
//   - XLEN_DEF : default operand width.
//   - a_is_signed / b_is_signed : operand signedness for each funct3.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ABS_A  = 3'd1,
    S_ABS_B  = 3'd2,
    S_ITER   = 3'd3,
    S_FIX_LO = 3'd4,
    S_FIX_HI = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  // rs1 is signed for MUL, MULH, MULHSU, DIV and REM.
  function automatic logic a_is_signed(input logic [2:0] f);
    return (f == OP_MUL) || (f == OP_MULH) || (f == OP_MULHSU) ||
           (f == OP_DIV) || (f == OP_REM);
  endfunction

  // rs2 is signed for MUL, MULH, DIV and REM.
  function automatic logic b_is_signed(input logic [2:0] f);
    return (f == OP_MUL) || (f == OP_MULH) || (f == OP_DIV) || (f == OP_REM);
  endfunction

endpackage

// File: rtl/ripple.sv
// ripple: plain ripple-carry adder, n+1 bits wide.
//   x, y : addends [n:0]
//   cin  : carry in
//   s    : sum [n:0]
//   cout : carry out of bit n
module ripple #(
  parameter int n = 32
) (
  input  logic [n:0] x,
  input  logic [n:0] y,
  input  logic       cin,
  output logic [n:0] s,
  output logic       cout
);

  always_comb begin
    logic c;
    s = '0;
    c = cin;
    for (int i = 0; i <= n; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer, fixed 37-cycle
// latency for every operation.  All arithmetic goes through a single
// XLEN+1-bit ripple adder whose operands are selected by the FSM state.
//   clk, rst  : clock, synchronous active-high reset
//   start     : request, sampled only in IDLE
//   op        : RV32M funct3
//   a, b      : rs1 / rs2, captured with start
//   busy      : high from the cycle after acceptance through DONE
//   done      : one-cycle pulse in DONE, result valid alongside
//   result    : held until the next done
//   dbg_state : current FSM state
//
// Handshake: start is a request that is accepted on any rising edge where the
// block is in IDLE; start in any other state is dropped.  done is a single
// cycle completion strobe and has no back-pressure.
//
// Register sharing: hi/lo hold the product halves for multiply and the
// remainder/quotient for divide; dvs holds |b| (multiply) or -|b| (divide).
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [2:0]      dbg_state
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic            sa_q, sa_d;
  logic            sb_q, sb_d;
  logic            bz_q, bz_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN:0]   dvs_q, dvs_d;
  logic            carry_q, carry_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;

  // Shared adder
  logic [XLEN:0] add_x, add_y, add_s;
  logic          add_cin, add_cout;

  ripple #(.n(XLEN)) u_add (
    .x    (add_x),
    .y    (add_y),
    .cin  (add_cin),
    .s    (add_s),
    .cout (add_cout)
  );

  logic is_div;
  logic neg_fix;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    bz_d     = bz_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dvs_d    = dvs_q;
    carry_d  = carry_q;
    busy_d   = busy_q;
    done_d   = done_q;
    result_d = result_q;
    add_x    = '0;
    add_y    = '0;
    add_cin  = 1'b0;
    neg_fix  = 1'b0;
    is_div   = op_q[2];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ABS_A;
          op_d    = op;
          a_d     = a;
          b_d     = b;
          sa_d    = a_is_signed(op) & a[XLEN-1];
          sb_d    = b_is_signed(op) & b[XLEN-1];
          bz_d    = (b == '0);
          cnt_d   = '0;
          hi_d    = '0;
          lo_d    = '0;
          dvs_d   = '0;
          carry_d = 1'b0;
          busy_d  = 1'b1;
        end
      end

      S_ABS_A: begin
        // |a| lands in lo: multiplier for multiply, dividend for divide.
        add_x   = {1'b0, (sa_q ? ~a_q : a_q)};
        add_cin = sa_q;
        lo_d    = add_s[XLEN-1:0];
        hi_d    = '0;
        state_d = S_ABS_B;
      end

      S_ABS_B: begin
        if (is_div) begin
          // -|b| in XLEN+1 bits: a negative b already is -|b| (sign-extend
          // it); otherwise negate {0,b}.
          add_x   = sb_q ? {1'b1, b_q} : ~{1'b0, b_q};
          add_cin = ~sb_q;
        end else begin
          add_x   = {1'b0, (sb_q ? ~b_q : b_q)};
          add_cin = sb_q;
        end
        dvs_d   = add_s;
        state_d = S_ITER;
      end

      S_ITER: begin
        if (is_div) begin
          // Restoring step: carry out means shifted >= |b|.
          add_x = {hi_q, lo_q[XLEN-1]};
          add_y = dvs_q;
          hi_d  = add_cout ? add_s[XLEN-1:0] : {hi_q[XLEN-2:0], lo_q[XLEN-1]};
          lo_d  = {lo_q[XLEN-2:0], add_cout};
        end else begin
          // Shift-add step: the XLEN-bit carry is add_s[XLEN].
          add_x = {1'b0, hi_q};
          add_y = lo_q[0] ? dvs_q : '0;
          hi_d  = add_s[XLEN:1];
          lo_d  = {add_s[0], lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_FIX_LO;
      end

      S_FIX_LO: begin
        neg_fix = is_div ? ((sa_q ^ sb_q) & ~bz_q) : (sa_q ^ sb_q);
        add_x   = {1'b0, (neg_fix ? ~lo_q : lo_q)};
        add_cin = neg_fix;
        lo_d    = add_s[XLEN-1:0];
        carry_d = add_s[XLEN];
        state_d = S_FIX_HI;
      end

      S_FIX_HI: begin
        // Multiply: upper half of a 2*XLEN negation, carry from FIX_LO.
        // Divide: independent negation of the remainder.
        neg_fix = is_div ? sa_q : (sa_q ^ sb_q);
        add_x   = {1'b0, (neg_fix ? ~hi_q : hi_q)};
        add_cin = is_div ? sa_q : carry_q;
        hi_d    = add_s[XLEN-1:0];
        case (op_q)
          OP_MUL:                       result_d = lo_q;
          OP_MULH, OP_MULHSU, OP_MULHU: result_d = hi_d;
          OP_DIV, OP_DIVU:              result_d = bz_q ? '1 : lo_q;
          default:                      result_d = bz_q ? a_q : hi_d;
        endcase
        done_d  = 1'b1;
        state_d = S_DONE;
      end

      S_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      bz_q     <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dvs_q    <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      bz_q     <= bz_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dvs_q    <= dvs_d;
      carry_q  <= carry_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign dbg_state = state_q;

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative RV32M multiply/divide sequencer for the execute stage. It runs all eight M-extension operations on one shared `ripple` carry adder, so there is no array multiplier or divider. The adder is reused for sign conversion, shift-add multiply, restoring divide and result negation. Latency is fixed at 37 cycles for every operation and operand value, so the pipeline stall logic only needs `busy`/`done`.

## Interface
- `XLEN`, default 32: operand width. The adder is `XLEN+1` bits wide.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request. Sampled only in IDLE.
- `op`  in  3: RV32M funct3. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `a`  in  XLEN: rs1 operand, captured with `start`.
- `b`  in  XLEN: rs2 operand, captured with `start`.
- `busy`  out  1: high from the cycle after acceptance through DONE.
- `done`  out  1: one-cycle pulse in DONE.
- `result`  out  XLEN: valid while `done`=1. Holds its value until the next `done`.

## Operation
- States, in this order: IDLE → ABS_A → ABS_B → ITER (XLEN cycles) → FIX_LO → FIX_HI → DONE → IDLE.
- Every path visits every state; a step with nothing to do adds 0 rather than being skipped.
- IDLE with `start`=1: latch `op`, `a`, `b`.
  - Compute `sa` = signed(a) & a[XLEN-1], where MUL/MULH/MULHSU/DIV/REM treat a as signed.
  - Compute `sb` = signed(b) & b[XLEN-1], where MUL/MULH/DIV/REM treat b as signed.
  - Compute `bz` = (b==0).
  - Clear the 5-bit iteration counter.
- ABS_A: adder computes |a| as (sa ? ~a : a) + sa.
- ABS_B:
  - Multiply: store |b|.
  - Divide: store the XLEN+1-bit two's-complement of |b| as `negdiv`.
- ITER, multiply:
  - If lo[0]=1, sum = hi + mcand; otherwise sum = hi + 0.
  - Then {hi,lo} ← {cout, sum, lo[XLEN-1:1]}.
- ITER, divide:
  - shifted = {rem[XLEN-1:0], quo[XLEN-1]}.
  - trial = shifted + negdiv.
  - If cout=1, rem ← trial; otherwise rem ← shifted.
  - quo ← {quo[XLEN-2:0], cout}.
- Counter increments every ITER cycle. The state exits ITER when the counter equals XLEN-1.
- Multiply sign fixup, with neg = sa^sb:
  - FIX_LO: lo ← ~lo + 1, and register the carry-out.
  - FIX_HI: hi ← ~hi + carry.
- Divide sign fixup:
  - FIX_LO negates quo if qneg = (sa^sb) & ~bz.
  - FIX_HI negates rem if rneg = sa.
- DONE result selection:
  - MUL → lo. MULH/MULHSU/MULHU → hi. DIV/DIVU → quo. REM/REMU → rem[XLEN-1:0].
  - Override when bz=1: DIV/DIVU gives all-ones, REM/REMU gives the original `a`.
- Signed overflow (−2^(XLEN−1) / −1) falls out of the algorithm naturally: quotient 0x80000000, remainder 0. No special case is needed.
- `start` while busy is ignored; there is no queue and no error flag.
- Reset values: state IDLE; `busy`, `done` = 0; `result` = 0; all internal registers = 0.

## Timing
- `start` sampled at edge k → `busy`=1 in cycle k+1.
- ABS_A is cycle k+1, ABS_B k+2, ITER k+3..k+34, FIX_LO k+35, FIX_HI k+36, DONE k+37.
- `done` and `result` are valid in cycle k+37. `busy` falls in k+38, and IDLE can accept a new `start` in that same cycle.
- Back-to-back throughput: one operation per 38 cycles.
- `rst` in any state: at the next edge the block is IDLE with `busy`=0 and `done`=0. No `done` is ever issued for the aborted operation.
- The adder is purely combinational between registers. The critical path is an XLEN+1-bit ripple plus a 2:1 mux.

## Structure
- Shared package `muldiv_pkg`:
  - funct3 localparams (`OP_MUL`..`OP_REMU`).
  - State encoding (`S_IDLE`..`S_DONE`).
  - `XLEN` default.
- Exactly one sub-module: the existing `ripple` adder, instantiated once with `n = XLEN`. Its operand muxes are driven by the state.
- No second adder and no `*` or `/` operators.

## Test plan
- MUL a=7, b=6 → `result`=42 with `done` exactly 37 cycles after `start`. `busy` is high for 37 cycles.
- MULH a=−3, b=5 → 0xFFFFFFFF. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU a=−1, b=2 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD. REM −7/2 → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Divide by zero:
  - DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV −5/0 → 0xFFFFFFFF; REM −5/0 → 0xFFFFFFFB.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000. REM of the same operands → 0.
- Busy and reset behaviour:
  - Pulse `start` again mid-ITER → ignored; the first result is unchanged.
  - Assert `rst` in the 10th ITER cycle → `busy`=0 next cycle and no `done`.
  - A fresh MUL 3×3 then returns 9 at +37 cycles.
